// File: rtl/senha_pkg.sv
// Shared key codes, FSM state type and decode helper for the password entry path.
package senha_pkg;

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_OK  = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ONE,
        ST_TWO,
        ST_SUBMIT,
        ST_WAIT
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for the keypad strobe.
module key_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic r_live;
    logic r_armed;

    // r_armed only sets once a genuinely sampled low is seen, so a key held
    // through reset release never looks like a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_prev  <= 1'b0;
            r_live  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_s1   <= i_din;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_live <= 1'b1;
            if (r_live && !r_s1)
                r_armed <= 1'b1;
        end
    end

    assign o_pulse = r_s2 & ~r_prev & r_armed;

endmodule

// File: rtl/senha_entry.sv
// Two-digit BCD password entry: key decode, inactivity timeout and a
// one-cycle submit handshake toward the downstream checker.
module senha_entry #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int WAIT_MIN       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_strobe,
    input  logic [3:0] key_code,
    input  logic       busy,
    output logic [7:0] senha,
    output logic       enter,
    output logic [1:0] digits,
    output logic       err,
    output logic       tmo
);

    import senha_pkg::*;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WW = (WAIT_MIN > 0) ? $clog2(WAIT_MIN + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MIN);

    state_t        r_state;
    logic [7:0]    r_senha;
    logic          r_enter;
    logic [1:0]    r_digits;
    logic          r_err;
    logic          r_tmo;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_wcnt;

    logic w_ev;
    logic w_digit;
    logic w_clr;
    logic w_ok;
    logic w_acc;

    key_sync_edge u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_din  (key_strobe),
        .o_pulse(w_ev)
    );

    assign w_digit = w_ev & is_digit(key_code);
    assign w_clr   = w_ev & (key_code == KEY_CLR);
    assign w_ok    = w_ev & (key_code == KEY_OK);
    assign w_acc   = w_digit | w_clr | w_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_senha  <= '0;
            r_enter  <= 1'b0;
            r_digits <= '0;
            r_err    <= 1'b0;
            r_tmo    <= 1'b0;
            r_cnt    <= '0;
            r_wcnt   <= '0;
        end else begin
            r_err   <= 1'b0;
            r_tmo   <= 1'b0;
            r_enter <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_digit) begin
                        r_senha  <= {4'h0, key_code};
                        r_digits <= 2'd1;
                        r_state  <= ST_ONE;
                    end else if (w_ok) begin
                        r_err <= 1'b1;
                    end else if (w_clr) begin
                        r_senha <= '0;
                    end
                end
                ST_ONE, ST_TWO: begin
                    // An accepted key on the timeout cycle takes precedence.
                    if (w_acc) begin
                        r_cnt <= '0;
                        if (w_clr) begin
                            r_senha  <= '0;
                            r_digits <= 2'd0;
                            r_state  <= ST_IDLE;
                        end else if (w_ok) begin
                            if (r_state == ST_TWO) begin
                                r_enter <= 1'b1;
                                r_state <= ST_SUBMIT;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else if (r_state == ST_ONE) begin
                            r_senha  <= {r_senha[3:0], key_code};
                            r_digits <= 2'd2;
                            r_state  <= ST_TWO;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt    <= '0;
                        r_senha  <= '0;
                        r_digits <= 2'd0;
                        r_tmo    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_SUBMIT: begin
                    r_cnt   <= '0;
                    r_wcnt  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= '0;
                    if (r_wcnt == WAIT_LAST) begin
                        if (!busy) begin
                            r_senha  <= '0;
                            r_digits <= 2'd0;
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + WW'(1);
                    end
                end
                default: begin
                    r_senha  <= '0;
                    r_digits <= 2'd0;
                    r_cnt    <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign senha  = r_senha;
    assign enter  = r_enter;
    assign digits = r_digits;
    assign err    = r_err;
    assign tmo    = r_tmo;

endmodule

// File: tb/tb_senha_entry.sv
// Directed and randomized checks of senha_entry against an event-level model.
module tb_senha_entry;

    localparam int TIMEOUT = 16;
    localparam int WMIN    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_strobe;
    logic [3:0] key_code;
    logic       busy;
    logic [7:0] senha;
    logic       enter;
    logic [1:0] digits;
    logic       err;
    logic       tmo;

    senha_entry #(.TIMEOUT_CYCLES(TIMEOUT), .WAIT_MIN(WMIN)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_strobe(key_strobe),
        .key_code  (key_code),
        .busy      (busy),
        .senha     (senha),
        .enter     (enter),
        .digits    (digits),
        .err       (err),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_err_dut = 0;
    int n_tmo_dut = 0;
    int n_enter_dut = 0;

    // Model: digits held, their values, cycles since last accepted key,
    // and cycles elapsed since a confirmed entry was handed off.
    int m_n, m_first, m_second, m_quiet, m_age;
    bit m_locked;
    bit exp_err, exp_tmo, exp_enter;
    bit hist[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_first = 0; m_second = 0; m_quiet = 0; m_age = 0;
        m_locked = 0; exp_err = 0; exp_tmo = 0; exp_enter = 0;
        hist.delete();
    endtask

    task automatic model_edge(input bit ev, input int code, input bit b);
        exp_err = 0; exp_tmo = 0; exp_enter = 0;
        if (m_locked) begin
            m_age++;
            if (m_age >= WMIN + 2 && !b) begin
                m_locked = 0;
                m_n = 0;
            end
        end else if (ev && code <= 9) begin
            m_quiet = 0;
            if (m_n == 0) begin m_first = code; m_n = 1; end
            else if (m_n == 1) begin m_second = code; m_n = 2; end
            else exp_err = 1;
        end else if (ev && code == 10) begin
            m_n = 0; m_quiet = 0;
        end else if (ev && code == 11) begin
            m_quiet = 0;
            if (m_n == 2) begin m_locked = 1; m_age = 0; exp_enter = 1; end
            else exp_err = 1;
        end else if (m_n > 0) begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
                m_n = 0; m_quiet = 0; exp_tmo = 1;
            end
        end
    endtask

    task automatic check_outputs();
        int es;
        es = (m_n == 2) ? m_first * 16 + m_second : ((m_n == 1) ? m_first : 0);
        chk("senha",  senha,  8'(es));
        chk("digits", digits, 8'(m_n));
        chk("enter",  enter,  8'(exp_enter));
        chk("err",    err,    8'(exp_err));
        chk("tmo",    tmo,    8'(exp_tmo));
        n_err_dut   += int'(err);
        n_tmo_dut   += int'(tmo);
        n_enter_dut += int'(enter);
    endtask

    task automatic step();
        bit ev;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            ev = (hist.size() >= 3) && hist[1] && !hist[2];
            hist.push_front(key_strobe);
            if (hist.size() > 4) hist.delete(4);
            model_edge(ev, int'(key_code), busy);
        end
        #1;
        check_outputs();
    endtask

    task automatic press(input logic [3:0] c, input int unsigned hold, input int unsigned gap);
        key_code = c;
        key_strobe = 1'b1;
        repeat (hold) step();
        key_strobe = 1'b0;
        repeat (gap) step();
    endtask

    task automatic async_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
    endtask

    initial begin
        int e0, t0, n0;
        logic [3:0] rc;
        int unsigned r;
        reset = 1'b1; key_strobe = 1'b0; key_code = 4'h0; busy = 1'b0;
        model_reset();
        repeat (3) step();
        chk("reset_senha", senha, 8'h00);
        chk("reset_digits", digits, 8'h00);
        reset = 1'b0;
        repeat (3) step();

        // Normal submit with busy handshake
        n0 = n_enter_dut;
        press(4'h4, 3, 2);
        press(4'h7, 3, 2);
        busy = 1'b1;
        press(4'hB, 3, 0);
        chk("s1_senha_47", senha, 8'h47);
        chk("s1_digits_2", digits, 8'd2);
        chk("s1_enter_hi", enter, 8'd1);
        repeat (5) step();
        busy = 1'b0;
        step();
        chk("s1_senha_cleared", senha, 8'h00);
        chk("s1_digits_0", digits, 8'd0);
        chk("s1_enter_once", 8'(n_enter_dut - n0), 8'd1);

        // Third digit rejected, then clear
        e0 = n_err_dut;
        press(4'h1, 3, 2);
        press(4'h2, 3, 2);
        press(4'h3, 3, 2);
        chk("s2_err_once", 8'(n_err_dut - e0), 8'd1);
        chk("s2_senha_12", senha, 8'h12);
        press(4'hA, 3, 2);
        chk("s2_clr_senha", senha, 8'h00);
        chk("s2_clr_digits", digits, 8'd0);
        chk("s2_clr_no_err", 8'(n_err_dut - e0), 8'd1);

        // Confirm from IDLE and ignored code
        e0 = n_err_dut; n0 = n_enter_dut;
        press(4'hB, 3, 2);
        chk("s3_err_once", 8'(n_err_dut - e0), 8'd1);
        chk("s3_no_enter", 8'(n_enter_dut - n0), 8'd0);
        press(4'hE, 3, 2);
        chk("s3_ignored_no_err", 8'(n_err_dut - e0), 8'd1);

        // Inactivity timeout, then a key landing on the timeout cycle
        t0 = n_tmo_dut;
        press(4'h5, 3, 0);
        repeat (TIMEOUT) step();
        chk("s4_tmo_once", 8'(n_tmo_dut - t0), 8'd1);
        chk("s4_tmo_senha", senha, 8'h00);
        chk("s4_tmo_digits", digits, 8'd0);
        t0 = n_tmo_dut;
        press(4'h5, 3, TIMEOUT - 3);
        press(4'h6, 3, 2);
        chk("s4_race_no_tmo", 8'(n_tmo_dut - t0), 8'd0);
        chk("s4_race_senha", senha, 8'h56);
        press(4'hA, 3, 2);

        // Reset while enter is high
        press(4'h9, 3, 2);
        press(4'h9, 3, 2);
        press(4'hB, 3, 0);
        chk("s5_enter_hi", enter, 8'd1);
        async_reset();
        chk("s5_enter_dropped", enter, 8'd0);
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();

        // Keys ignored during WAIT, then reset in WAIT with key held across release
        e0 = n_err_dut;
        busy = 1'b1;
        press(4'h9, 3, 2);
        press(4'h9, 3, 2);
        press(4'hB, 3, 2);
        press(4'h3, 3, 2);
        press(4'hA, 3, 2);
        chk("s6_wait_senha", senha, 8'h99);
        chk("s6_wait_digits", digits, 8'd2);
        chk("s6_wait_no_err", 8'(n_err_dut - e0), 8'd0);
        key_code = 4'h4;
        key_strobe = 1'b1;
        async_reset();
        chk("s6_rst_senha", senha, 8'h00);
        repeat (2) step();
        reset = 1'b0;
        busy = 1'b0;
        repeat (6) step();
        chk("s6_held_no_event", digits, 8'd0);
        key_strobe = 1'b0;
        repeat (3) step();
        press(4'h2, 3, 2);
        chk("s6_after_senha", senha, 8'h02);
        press(4'hA, 3, 2);

        // Randomized key traffic
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      rc = 4'($urandom_range(0, 9));
            else if (r < 72) rc = 4'hA;
            else if (r < 87) rc = 4'hB;
            else             rc = 4'($urandom_range(12, 15));
            busy = ($urandom_range(0, 2) == 0);
            press(rc, $urandom_range(3, 5),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(10, 20) : $urandom_range(1, 4));
        end
        busy = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
